handshake_fifo_buffer: RTL and testbench
========================================

Name: handshake_fifo_buffer

Overview:
- Elastic FIFO buffer stage in the dataflow handshake fabric.
- Sits directly downstream of constant, operator and fork stages.
- Absorbs their valid/data output and re-presents it downstream from registers, breaking both the combinational valid path and the ready path.
- Preserves order; no data loss or duplication under any backpressure pattern.

Parameters:
- DATA_WIDTH, 32, width of the ins/outs payload.
- DEPTH, 4, number of storage entries; legal values are 2 or more (need not be a power of two).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the clk rising edge, reset while rst==0.
- ins  input  DATA_WIDTH  upstream payload.
- ins_valid  input  1  upstream valid.
- ins_ready  output  1  buffer can accept this cycle.
- outs  output  DATA_WIDTH  head-of-queue payload.
- outs_valid  output  1  head entry present.
- outs_ready  input  1  downstream accepts.

Behaviour:
- Storage:
  - DEPTH x DATA_WIDTH register array.
  - Write pointer wptr and read pointer rptr, each in 0..DEPTH-1.
  - Occupancy count cnt, width $clog2(DEPTH+1), in 0..DEPTH.
- Transfer rules:
  - Push when ins_valid && ins_ready.
  - Pop when outs_valid && outs_ready.
- Derived outputs:
  - ins_ready = (cnt != DEPTH). Depends only on registered state, never on outs_ready; no same-cycle bypass when full.
  - outs_valid = (cnt != 0). Depends only on registered state, never on ins_valid.
  - outs = mem[rptr]. Value is don't-care when outs_valid==0; the bench must not check it.
- Updates per edge:
  - Push only: mem[wptr] <= ins, wptr advances, cnt+1.
  - Pop only: rptr advances, cnt-1.
  - Push and pop together: both pointers advance, cnt unchanged. Legal at any cnt with 0<cnt<DEPTH.
  - Neither: state holds.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. Explicit compare, not modulo power-of-two.
- Latency: a word pushed in cycle N is first visible on outs with outs_valid=1 in cycle N+1 (if the queue was empty). No zero-latency path.
- Throughput: 1 word/cycle sustained when 0<cnt<DEPTH and both sides are active.
- Full (cnt==DEPTH):
  - ins_ready=0, so ins_valid is ignored.
  - A pop in this cycle makes ins_ready=1 in the next cycle.
- Empty (cnt==0):
  - outs_valid=0, so outs_ready is ignored.
  - A push in this cycle makes outs_valid=1 in the next cycle.
- Reset (rst==0 at an edge):
  - cnt=0, wptr=0, rptr=0.
  - Hence outs_valid=0 and ins_ready=1 from the first cycle after reset.
  - Memory contents are not reset.
  - Reset overrides any simultaneous push or pop.
  - Reset mid-operation discards all stored words; none reappear after release.
- Handshake protocol:
  - Upstream must hold ins/ins_valid stable until accepted.
  - This block guarantees outs/outs_valid stay stable while outs_valid && !outs_ready.

Optional Feature:
- Macro: HANDSHAKE_FIFO_BUFFER_WATERMARK_EN.
- When defined:
  - Adds output port max_occ, width $clog2(DEPTH+1).
  - max_occ is a registered high-water mark of cnt: updated to the post-edge cnt whenever that exceeds the current max_occ; otherwise it holds.
  - Cleared to 0 on reset.
  - Saturates naturally at DEPTH.
- When undefined: the port and its logic are absent. Datapath behaviour is identical in both builds.

Test Plan:
- Reset then idle (DATA_WIDTH=27, DEPTH=4): hold rst=0 for 2 cycles, then release → outs_valid=0, ins_ready=1, no spurious transfer for 10 idle cycles.
- Single word: push 27'h7BDCCDC at cycle N, outs_ready=1 → outs_valid=1 and outs=27'h7BDCCDC at cycle N+1; outs_valid=0 at N+2.
- Fill and stall: outs_ready=0, push 1,2,3,4 on consecutive cycles → ins_ready=0 after the 4th push; a 5th offered word (5) is not accepted; set outs_ready=1 → pops 1,2,3,4 in order; ins_ready=1 the cycle after the first pop.
- Streaming with wrap (DEPTH=3): ins_valid and outs_ready both held at 1, push 0..19 → outs sequence is 0..19 exactly, one word per cycle after the first, pointers wrap 2→0 without loss.
- Random backpressure: 1000 words, ins_valid and outs_ready each random at 50% → scoreboard matches in order; outs stable whenever outs_valid && !outs_ready.
- Reset mid-operation: with cnt=3, assert rst=0 together with ins_valid=1 for one cycle → next cycle outs_valid=0 and cnt=0; none of the old words or the coincident word ever appear. With HANDSHAKE_FIFO_BUFFER_WATERMARK_EN, max_occ=3 before this reset and 0 after it.

Source files
------------

// File: rtl/handshake_fifo_buffer.sv
// Elastic FIFO stage that registers both valid and ready for the dataflow handshake fabric.
// Define HANDSHAKE_FIFO_BUFFER_WATERMARK_EN to add the max_occ high-water-mark output.
module handshake_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
`ifdef HANDSHAKE_FIFO_BUFFER_WATERMARK_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] max_occ
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr, rptr;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  push, pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] adv(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Both handshake outputs come from registered state only.
    assign ins_ready  = (cnt != CNT_W'(DEPTH));
    assign outs_valid = (cnt != '0);
    assign outs       = mem[rptr];

    assign push = ins_valid && ins_ready;
    assign pop  = outs_valid && outs_ready;

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)
            cnt_nxt = cnt + CNT_W'(1);
        else if (!push && pop)
            cnt_nxt = cnt - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (push)
                wptr <= adv(wptr);
            if (pop)
                rptr <= adv(rptr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push)
            mem[wptr] <= ins;
    end

`ifdef HANDSHAKE_FIFO_BUFFER_WATERMARK_EN
    always_ff @(posedge clk) begin
        if (!rst)
            max_occ <= '0;
        else if (cnt_nxt > max_occ)
            max_occ <= cnt_nxt;
    end
`endif

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Directed bench for handshake_fifo_buffer: DEPTH=4 instance for most steps, DEPTH=3 for wrap streaming.
module tb_handshake_fifo_buffer;

    localparam int DW = 27;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] ins, outs;
    logic          ins_valid, ins_ready, outs_valid, outs_ready;
    logic [DW-1:0] ins2, outs2;
    logic          ins_valid2, ins_ready2, outs_valid2, outs_ready2;
`ifdef HANDSHAKE_FIFO_BUFFER_WATERMARK_EN
    logic [2:0] max_occ, max_occ2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    handshake_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready)
`ifdef HANDSHAKE_FIFO_BUFFER_WATERMARK_EN
        , .max_occ(max_occ)
`endif
    );

    handshake_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst),
        .ins(ins2), .ins_valid(ins_valid2), .ins_ready(ins_ready2),
        .outs(outs2), .outs_valid(outs_valid2), .outs_ready(outs_ready2)
`ifdef HANDSHAKE_FIFO_BUFFER_WATERMARK_EN
        , .max_occ(max_occ2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_w, stall_data;
        logic          stall_prev, accepted;
        int            sent, rcvd, cyc;

        rst = 1'b0; ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
        ins2 = '0; ins_valid2 = 1'b0; outs_ready2 = 1'b0;

        // Reset then idle
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_outs_valid", {31'd0, outs_valid}, 32'd0);
            chk("idle_ins_ready", {31'd0, ins_ready}, 32'd1);
        end
        chk("idle3_outs_valid", {31'd0, outs_valid2}, 32'd0);
        chk("idle3_ins_ready", {31'd0, ins_ready2}, 32'd1);
`ifdef HANDSHAKE_FIFO_BUFFER_WATERMARK_EN
        chk("idle_max_occ", {29'd0, max_occ}, 32'd0);
`endif

        // Single word, one-cycle latency
        ins = 27'h7BDCCDC; ins_valid = 1'b1; outs_ready = 1'b1;
        step();
        ins_valid = 1'b0;
        chk("single_valid_n1", {31'd0, outs_valid}, 32'd1);
        chk("single_data_n1", {5'd0, outs}, 32'h7BDCCDC);
        step();
        chk("single_valid_n2", {31'd0, outs_valid}, 32'd0);
        chk("single_ready_n2", {31'd0, ins_ready}, 32'd1);

        // Fill and stall
        outs_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ins = DW'(i); ins_valid = 1'b1;
            step();
        end
        chk("full_ins_ready", {31'd0, ins_ready}, 32'd0);
        chk("full_outs_valid", {31'd0, outs_valid}, 32'd1);
        chk("full_head", {5'd0, outs}, 32'd1);
`ifdef HANDSHAKE_FIFO_BUFFER_WATERMARK_EN
        chk("full_max_occ", {29'd0, max_occ}, 32'd4);
`endif
        ins = DW'(5);
        step();
        chk("full_reject5_ready", {31'd0, ins_ready}, 32'd0);
        chk("full_reject5_head", {5'd0, outs}, 32'd1);
        // 5 stays offered and enters after the first pop frees a slot
        outs_ready = 1'b1;
        step();
        chk("after_pop_ins_ready", {31'd0, ins_ready}, 32'd1);
        chk("drain_2", {5'd0, outs}, 32'd2);
        step();
        ins_valid = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            chk("drain_valid", {31'd0, outs_valid}, 32'd1);
            chk("drain_data", {5'd0, outs}, 32'(i));
            step();
        end
        chk("drain_empty", {31'd0, outs_valid}, 32'd0);
        outs_ready = 1'b0;

        // Streaming with wrap on DEPTH=3
        ins2 = '0; ins_valid2 = 1'b1; outs_ready2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("stream_valid", {31'd0, outs_valid2}, 32'd1);
            chk("stream_data", {5'd0, outs2}, 32'(i));
            chk("stream_ready", {31'd0, ins_ready2}, 32'd1);
            if (i == 19) ins_valid2 = 1'b0;
            else ins2 = DW'(i + 1);
        end
        step();
        chk("stream_end_empty", {31'd0, outs_valid2}, 32'd0);
        outs_ready2 = 1'b0;

        // Random backpressure with scoreboard
        sent = 0; rcvd = 0; cyc = 0;
        stall_prev = 1'b0; stall_data = '0; accepted = 1'b0;
        ins_valid = 1'b0;
        while (rcvd < 1000 && cyc < 20000) begin
            if (!ins_valid && sent < 1000 && $urandom_range(1, 0) == 1) begin
                ins = DW'($urandom());
                ins_valid = 1'b1;
            end
            outs_ready = ($urandom_range(1, 0) == 1);
            if (stall_prev) begin
                chk("rand_stall_valid", {31'd0, outs_valid}, 32'd1);
                chk("rand_stall_data", {5'd0, outs}, {5'd0, stall_data});
            end
            if (outs_valid && outs_ready) begin
                if (q.size() == 0) begin
                    chk("rand_pop_nonempty", 32'(q.size()), 32'd1);
                end else begin
                    exp_w = q.pop_front();
                    chk("rand_data", {5'd0, outs}, {5'd0, exp_w});
                end
                rcvd++;
            end
            if (ins_valid && ins_ready) begin
                q.push_back(ins);
                sent++;
                accepted = 1'b1;
            end
            stall_prev = outs_valid && !outs_ready;
            stall_data = outs;
            step();
            cyc++;
            if (accepted) begin
                ins_valid = 1'b0;
                accepted = 1'b0;
            end
        end
        chk("rand_all_received", 32'(rcvd), 32'd1000);
        chk("rand_queue_empty", 32'(q.size()), 32'd0);
        ins_valid = 1'b0; outs_ready = 1'b0;

        // Reset mid-operation with cnt=3 and a coincident push
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ins = DW'(27'h100 + i); ins_valid = 1'b1;
            step();
        end
        chk("pre_rst_valid", {31'd0, outs_valid}, 32'd1);
        chk("pre_rst_head", {5'd0, outs}, 32'h100);
        chk("pre_rst_ready", {31'd0, ins_ready}, 32'd1);
`ifdef HANDSHAKE_FIFO_BUFFER_WATERMARK_EN
        chk("pre_rst_max_occ", {29'd0, max_occ}, 32'd3);
`endif
        ins = 27'h5A5A5A5; ins_valid = 1'b1; rst = 1'b0;
        step();
        rst = 1'b1; ins_valid = 1'b0; outs_ready = 1'b1;
        chk("rst_mid_valid", {31'd0, outs_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, ins_ready}, 32'd1);
`ifdef HANDSHAKE_FIFO_BUFFER_WATERMARK_EN
        chk("rst_mid_max_occ", {29'd0, max_occ}, 32'd0);
`endif
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_mid_stays_empty", {31'd0, outs_valid}, 32'd0);
        end
        ins = 27'h0ABCDEF; ins_valid = 1'b1;
        step();
        ins_valid = 1'b0;
        chk("post_rst_first_valid", {31'd0, outs_valid}, 32'd1);
        chk("post_rst_first_data", {5'd0, outs}, 32'h0ABCDEF);
        step();
        chk("post_rst_empty", {31'd0, outs_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
